// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared definitions for the CPU/DMA bus arbiter: bus widths, active-low
//   handshake levels, read/write encoding, arbiter state codes and a counter
//   width helper.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH     = 16;

  // Handshake levels for the active-low control lines (breq_, bgrt_, ...).
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Bus direction encoding for rw_.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [2:0] {
    ARB_CPU   = 3'd0,  // CPU owns the bus (default)
    ARB_HOLD  = 3'd1,  // CPU asked to stall, waiting for cpu_hlda_
    ARB_DMA   = 3'd2,  // DMA owns the bus
    ARB_REL   = 3'd3,  // DMA just released, bus parked in read
    ARB_GUARD = 3'd4   // CPU guard window, breq_ not honoured
  } arb_state_e;

  // Counter width for a terminal count of limit-1, with one spare bit so the
  // reload value never aliases to zero.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/arb_cycle_cnt.sv
// -----------------------------------------------------------------------------
// arb_cycle_cnt
//   Clear/enable down counter with a terminal-count strobe. A clear loads
//   LIMIT-1; each enabled cycle counts down, and the enabled cycle that sees
//   zero raises tc and reloads LIMIT-1, so tc repeats every LIMIT enabled
//   cycles. The count never decrements through zero.
//
// Ports
//   clk     in  1  clock
//   reset_  in  1  asynchronous active-low reset (count -> 0)
//   clear   in  1  synchronous load of LIMIT-1 (wins over enable)
//   enable  in  1  count this cycle
//   tc      out 1  terminal count, enabled cycle with count == 0
// -----------------------------------------------------------------------------
module arb_cycle_cnt
  import bus_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int              W    = cnt_width(LIMIT);
  localparam logic [W-1:0]    LOAD = W'(LIMIT - 1);

  logic [W-1:0] count;

  // The owner clears the counter in every cycle it is not counting, so the
  // reset value of zero is never seen by an enabled cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable) begin
      count <= (count == '0) ? LOAD : count - 1'b1;
    end
  end

  assign tc = enable && !clear && (count == '0);

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Arbitrates the single memory/I-O bus between the CPU (default owner) and
//   the DMA controller. A DMA request first stalls the CPU through cpu_hold_;
//   bgrt_ is granted only once the CPU acknowledges with cpu_hlda_. After each
//   DMA release the bus is parked in read for one cycle and the CPU keeps the
//   bus for a guard window of CPU_GUARD cycles. A CPU that fails to acknowledge
//   within HOLD_TIMEOUT cycles gets a one-cycle low pulse on hold_err_, and the
//   arbiter keeps waiting.
//
// Parameters
//   CPU_GUARD     guard cycles after a DMA release (>= 1)
//   HOLD_TIMEOUT  cycles without hlda per hold_err_ pulse (>= 2)
//
// Ports
//   clk        in   1               clock, all state on posedge
//   reset_     in   1               asynchronous active-low reset
//   breq_      in   1               DMA bus request (active low)
//   bgrt_      out  1               DMA bus grant (active low, registered)
//   cpu_hold_  out  1               CPU stall request (active low, registered)
//   cpu_hlda_  in   1               CPU hold acknowledge (active low)
//   cpu_addr   in   BUS_ADDR_WIDTH  CPU address
//   cpu_odata  in   DATA_WIDTH      CPU write data
//   cpu_rw_    in   1               CPU read/write
//   dma_addr   in   BUS_ADDR_WIDTH  DMA address
//   dma_odata  in   DATA_WIDTH      DMA write data
//   dma_rw_    in   1               DMA read/write
//   addr       out  BUS_ADDR_WIDTH  bus address from the current owner
//   odata      out  DATA_WIDTH      bus write data from the current owner
//   rw_        out  1               bus read/write from the current owner
//   dma_busy   out  1               DMA owns the bus
//   hold_err_  out  1               hold-timeout pulse (active low, registered)
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int CPU_GUARD    = 4,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      breq_,
  output logic                      bgrt_,
  output logic                      cpu_hold_,
  input  logic                      cpu_hlda_,
  input  logic [BUS_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_odata,
  input  logic                      cpu_rw_,
  input  logic [BUS_ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]     dma_odata,
  input  logic                      dma_rw_,
  output logic [BUS_ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]     odata,
  output logic                      rw_,
  output logic                      dma_busy,
  output logic                      hold_err_
);

  arb_state_e state, next_state;

  logic hold_tc, guard_tc;
  logic bgrt_nxt, cpu_hold_nxt, hold_err_nxt;

  // ---------------------------------------------------------------------------
  // Cycle counters. Each is held cleared outside its own state, so entering
  // the state always starts a full window.
  // ---------------------------------------------------------------------------
  arb_cycle_cnt #(.LIMIT(HOLD_TIMEOUT)) u_hold_cnt (
    .clk    (clk),
    .reset_ (reset_),
    .clear  (state != ARB_HOLD),
    .enable ((state == ARB_HOLD) && (breq_ == ENABLE_) && (cpu_hlda_ == DISABLE_)),
    .tc     (hold_tc)
  );

  arb_cycle_cnt #(.LIMIT(CPU_GUARD)) u_guard_cnt (
    .clk    (clk),
    .reset_ (reset_),
    .clear  (state != ARB_GUARD),
    .enable (state == ARB_GUARD),
    .tc     (guard_tc)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ARB_CPU;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assigning a default before the case keeps every path covered, so no
  // latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      ARB_CPU: begin
        // hlda is only looked at in ARB_HOLD, even if it is already low here.
        if (breq_ == ENABLE_) next_state = ARB_HOLD;
      end
      ARB_HOLD: begin
        // A withdrawn request wins over a late acknowledge.
        if (breq_ == DISABLE_)          next_state = ARB_CPU;
        else if (cpu_hlda_ == ENABLE_)  next_state = ARB_DMA;
      end
      ARB_DMA: begin
        // No preemption and cpu_hlda_ is ignored: only the DMA ends a tenure.
        if (breq_ == DISABLE_) next_state = ARB_REL;
      end
      ARB_REL: begin
        next_state = ARB_GUARD;
      end
      ARB_GUARD: begin
        // breq_ is ignored until the last guard cycle; a request present on
        // that edge skips ARB_CPU.
        if (guard_tc) next_state = (breq_ == ENABLE_) ? ARB_HOLD : ARB_CPU;
      end
      default: begin
        next_state = ARB_CPU;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered handshakes, decoded from
  // next_state, plus the combinational bus mux from the registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    bgrt_nxt     = (next_state == ARB_DMA) ? ENABLE_ : DISABLE_;
    // The CPU stays stalled from the request until the release cycle is over.
    cpu_hold_nxt = (next_state inside {ARB_HOLD, ARB_DMA, ARB_REL}) ? ENABLE_ : DISABLE_;
    hold_err_nxt = hold_tc ? ENABLE_ : DISABLE_;

    addr     = cpu_addr;
    odata    = cpu_odata;
    rw_      = cpu_rw_;
    dma_busy = 1'b0;
    unique case (state)
      ARB_DMA: begin
        addr     = dma_addr;
        odata    = dma_odata;
        rw_      = dma_rw_;
        dma_busy = 1'b1;
      end
      ARB_REL: begin
        // The DMA leaves its last rw_ at write; park the bus in read.
        rw_ = READ;
      end
      default: begin
      end
    endcase
    // Keep the bus out of write while reset is held.
    if (!reset_) rw_ = READ;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bgrt_     <= DISABLE_;
      cpu_hold_ <= DISABLE_;
      hold_err_ <= DISABLE_;
    end else begin
      bgrt_     <= bgrt_nxt;
      cpu_hold_ <= cpu_hold_nxt;
      hold_err_ <= hold_err_nxt;
    end
  end

endmodule
